i2c_slave: RTL

Clock-oversampled I2C responder: the target-side end of the link driven by `i2c_master`, sharing the same open-drain `sda` and the `scl` it generates. It detects START/STOP, matches a fixed 7-bit address, ACKs, and streams write bytes out and read bytes in over a simple byte interface. It sits beside `i2c_master` on the bus in the top-level benches and in the design as the register-side peripheral port.

---
 rtl/i2c_slave.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// I2C target port: oversamples scl/sda on clk_50, answers SLAVE_ADDR,
// and moves write bytes out and read bytes in through a byte interface.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  input  logic [7:0] tx_data,
  output logic       rd_req,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WRITE     = 3'd3,
    WRITE_ACK = 3'd4,
    READ      = 3'd5,
    READ_ACK  = 3'd6
  } state_t;

  // Byte handshake: wr_valid is a 1-cycle strobe qualifying wr_data (no back-pressure);
  // rd_req is a 1-cycle strobe during which tx_data must be valid, it is sampled that edge.

  logic   scl_m, scl_s, scl_d;
  logic   sda_m, sda_s, sda_d;
  logic   scl_rise, scl_fall, start_ev, stop_ev;

  state_t state_q, state_n;
  logic [7:0] shift_q, shift_n;
  logic [3:0] cnt_q, cnt_n;
  logic       sda_oe_q, sda_oe_n;
  logic       rw_q, rw_n;
  logic       busy_n;
  logic [7:0] wr_data_n;
  logic       wr_valid_n;
  logic [7:0] byte_in;

  // Synchronisers idle high so leaving reset on a quiet bus produces no events.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      {scl_m, scl_s, scl_d} <= 3'b111;
      {sda_m, sda_s, sda_d} <= 3'b111;
    end else begin
      scl_m <= scl;
      scl_s <= scl_m;
      scl_d <= scl_s;
      sda_m <= sda;
      sda_s <= sda_m;
      sda_d <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_in  = {shift_q[6:0], sda_s};

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= 8'h00;
      cnt_q    <= 4'd0;
      sda_oe_q <= 1'b0;
      rw_q     <= 1'b0;
      busy     <= 1'b0;
      wr_data  <= 8'h00;
      wr_valid <= 1'b0;
    end else begin
      state_q  <= state_n;
      shift_q  <= shift_n;
      cnt_q    <= cnt_n;
      sda_oe_q <= sda_oe_n;
      rw_q     <= rw_n;
      busy     <= busy_n;
      wr_data  <= wr_data_n;
      wr_valid <= wr_valid_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    shift_n    = shift_q;
    cnt_n      = cnt_q;
    sda_oe_n   = sda_oe_q;
    rw_n       = rw_q;
    busy_n     = busy;
    wr_data_n  = wr_data;
    wr_valid_n = 1'b0;
    rd_req     = 1'b0;

    if (start_ev) begin
      state_n  = ADDR;
      cnt_n    = 4'd0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (stop_ev) begin
      state_n  = IDLE;
      cnt_n    = 4'd0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_n = 4'd0;
        end

        ADDR: begin
          if (scl_rise) begin
            shift_n = byte_in;
            if (cnt_q == 4'd7) begin
              cnt_n = 4'd0;
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state_n = ADDR_ACK;
                busy_n  = 1'b1;
                rw_n    = byte_in[0];
              end else begin
                state_n = IDLE;
              end
            end else begin
              cnt_n = cnt_q + 4'd1;
            end
          end
        end

        // cnt marks the ACK phase: 0 = waiting to drive, 1 = ACK on the bus.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_oe_n = 1'b1;
              cnt_n    = 4'd1;
            end else begin
              cnt_n = 4'd0;
              if (rw_q) begin
                rd_req   = 1'b1;
                shift_n  = tx_data;
                sda_oe_n = ~tx_data[7];
                state_n  = READ;
              end else begin
                sda_oe_n = 1'b0;
                state_n  = WRITE;
              end
            end
          end
        end

        WRITE: begin
          if (scl_rise) begin
            shift_n = byte_in;
            if (cnt_q == 4'd7) begin
              wr_data_n  = byte_in;
              wr_valid_n = 1'b1;
              cnt_n      = 4'd0;
              state_n    = WRITE_ACK;
            end else begin
              cnt_n = cnt_q + 4'd1;
            end
          end
        end

        WRITE_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_oe_n = 1'b1;
              cnt_n    = 4'd1;
            end else begin
              sda_oe_n = 1'b0;
              cnt_n    = 4'd0;
              state_n  = WRITE;
            end
          end
        end

        // The MSB went out on entry; each fall presents the next bit.
        READ: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              sda_oe_n = 1'b0;
              cnt_n    = 4'd0;
              state_n  = READ_ACK;
            end else begin
              cnt_n    = cnt_q + 4'd1;
              shift_n  = {shift_q[6:0], 1'b0};
              sda_oe_n = ~shift_q[6];
            end
          end
        end

        READ_ACK: begin
          if (scl_rise && cnt_q == 4'd0) begin
            if (sda_s) begin
              state_n  = IDLE;
              busy_n   = 1'b0;
              sda_oe_n = 1'b0;
            end else begin
              cnt_n = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            rd_req   = 1'b1;
            shift_n  = tx_data;
            sda_oe_n = ~tx_data[7];
            cnt_n    = 4'd0;
            state_n  = READ;
          end
        end

        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
      endcase
    end
  end

  assign sda   = sda_oe_q ? 1'b0 : 1'bz;
  assign state = state_q;

endmodule
